// File: rtl/hazard_scoreboard_pkg.sv
// Shared encodings and helpers for the forwarding / hazard scoreboard block.
package hazard_scoreboard_pkg;

    // EX operand mux select encodings
    localparam logic [1:0] FWD_RF  = 2'd0;
    localparam logic [1:0] FWD_MEM = 2'd1;
    localparam logic [1:0] FWD_WB  = 2'd2;

    // MEM holds the younger producer, so it wins over WB
    function automatic logic [1:0] fwd_pick(input logic hit_mem, input logic hit_wb);
        if (hit_mem)
            return FWD_MEM;
        if (hit_wb)
            return FWD_WB;
        return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Pipeline-side bundle for the hazard scoreboard: issue info, stage tags, mux selects, stall.
interface hazard_scoreboard_if #(
    parameter int REGISTER_ADDR_WIDTH = 5,
    parameter int NUM_SRC             = 2,
    parameter int LAT_WIDTH           = 3,
    parameter int PERF_WIDTH          = 16
);
    logic                                   issue_valid;
    logic [REGISTER_ADDR_WIDTH-1:0]         issue_rd;
    logic                                   issue_reg_write;
    logic                                   issue_long_lat;
    logic [LAT_WIDTH-1:0]                   issue_latency;
    logic                                   flush;
    logic [NUM_SRC*REGISTER_ADDR_WIDTH-1:0] rs_ID;
    logic [NUM_SRC*REGISTER_ADDR_WIDTH-1:0] rs_EX;
    logic [REGISTER_ADDR_WIDTH-1:0]         rd_EX;
    logic [REGISTER_ADDR_WIDTH-1:0]         rd_MEM;
    logic [REGISTER_ADDR_WIDTH-1:0]         rd_WB;
    logic                                   reg_write_EX;
    logic                                   reg_write_MEM;
    logic                                   reg_write_WB;
    logic                                   mem_read_EX;
    logic [2*NUM_SRC-1:0]                   forward_sel_EX;
    logic [NUM_SRC-1:0]                     forward_wb_ID;
    logic                                   stall_ID;
    logic                                   sb_busy;
    logic [PERF_WIDTH-1:0]                  stall_cycles;

    modport master (
        output issue_valid, issue_rd, issue_reg_write, issue_long_lat, issue_latency, flush,
               rs_ID, rs_EX, rd_EX, rd_MEM, rd_WB, reg_write_EX, reg_write_MEM, reg_write_WB,
               mem_read_EX,
        input  forward_sel_EX, forward_wb_ID, stall_ID, sb_busy, stall_cycles
    );

    modport slave (
        input  issue_valid, issue_rd, issue_reg_write, issue_long_lat, issue_latency, flush,
               rs_ID, rs_EX, rd_EX, rd_MEM, rd_WB, reg_write_EX, reg_write_MEM, reg_write_WB,
               mem_read_EX,
        output forward_sel_EX, forward_wb_ID, stall_ID, sb_busy, stall_cycles
    );

endinterface

// File: rtl/hazard_scoreboard_sb_counter.sv
// Per-register countdown: cycles until a long-latency producer's result reaches WB.
module hazard_sb_counter
    import hazard_scoreboard_pkg::*;
#(
    parameter int LAT_WIDTH = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [LAT_WIDTH-1:0] load_val,
    output logic [LAT_WIDTH-1:0] cnt,
    output logic                 zero
);

    // A reload overrides the decrement so the newest producer defines the wait
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// Forwarding selects, load-use / long-latency stall and stall-cycle counter for the five-stage core.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int REGISTER_ADDR_WIDTH = 5,
    parameter int NUM_SRC             = 2,
    parameter int LAT_WIDTH           = 3,
    parameter int PERF_WIDTH          = 16
) (
    input  logic               clk,
    input  logic               rst,
    hazard_scoreboard_if.slave hz
);

    localparam int W    = REGISTER_ADDR_WIDTH;
    localparam int NREG = 2 ** W;

    logic [NREG-1:0][LAT_WIDTH-1:0] cnt_all;
    logic [NREG-1:1]                cnt_zero;
    logic [NREG-1:1]                cnt_ld;
    logic [NUM_SRC-1:0][1:0]        fwd_sel;
    logic [NUM_SRC-1:0]             wb_id;
    logic [NUM_SRC-1:0]             lu_hit;
    logic [NUM_SRC-1:0]             raw_hit;
    logic                           load_use;
    logic                           sb_raw;
    logic                           sb_waw;
    logic                           stall;
    logic                           accept;
    logic                           take_entry;
    logic [PERF_WIDTH-1:0]          perf_q;

    // ---------------- per-operand compare ----------------
    for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
        logic [W-1:0] rs_id;
        logic [W-1:0] rs_ex;
        logic         mem_hit;
        logic         wb_hit;

        assign rs_id   = hz.rs_ID[k*W +: W];
        assign rs_ex   = hz.rs_EX[k*W +: W];
        assign mem_hit = (rs_ex != '0) && (rs_ex == hz.rd_MEM) && hz.reg_write_MEM;
        assign wb_hit  = (rs_ex != '0) && (rs_ex == hz.rd_WB)  && hz.reg_write_WB;

        assign fwd_sel[k] = fwd_pick(mem_hit, wb_hit);
        assign wb_id[k]   = (rs_id == hz.rd_WB) && hz.reg_write_WB && (hz.rd_WB != '0);
        assign lu_hit[k]  = (rs_id == hz.rd_EX);
        // cnt==1 means WB next cycle, which the bypass paths cover
        assign raw_hit[k] = (rs_id != '0) && (cnt_all[rs_id] > LAT_WIDTH'(1));
    end

    assign hz.forward_sel_EX = fwd_sel;
    assign hz.forward_wb_ID  = wb_id;

    // ---------------- stall tree ----------------
    assign load_use = hz.mem_read_EX && hz.reg_write_EX && (hz.rd_EX != '0) && (|lu_hit);
    assign sb_raw   = |raw_hit;
    // Decoded from the ID fields only, so stall never depends on issue_valid
    assign sb_waw   = hz.issue_reg_write && !hz.issue_long_lat && (hz.issue_rd != '0)
                      && (cnt_all[hz.issue_rd] != '0);
    assign stall    = load_use || sb_raw || sb_waw;

    assign hz.stall_ID = stall;

    // ---------------- scoreboard ----------------
    assign accept     = hz.issue_valid && !stall && !hz.flush;
    assign take_entry = accept && hz.issue_long_lat && hz.issue_reg_write
                        && (hz.issue_latency != '0);

    assign cnt_all[0] = '0;

    for (genvar r = 1; r < NREG; r++) begin : g_cnt
        assign cnt_ld[r] = take_entry && (hz.issue_rd == W'(r));

        hazard_sb_counter #(
            .LAT_WIDTH (LAT_WIDTH)
        ) u_cnt (
            .clk      (clk),
            .rst      (rst),
            .load     (cnt_ld[r]),
            .load_val (hz.issue_latency),
            .cnt      (cnt_all[r]),
            .zero     (cnt_zero[r])
        );
    end

    assign hz.sb_busy = ~(&cnt_zero);

    // ---------------- saturating stall counter ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            perf_q <= '0;
        else if (stall && (perf_q != '1))
            perf_q <= perf_q + 1'b1;
    end

    assign hz.stall_cycles = perf_q;

endmodule
